if_fetch: RTL
=============

# if_fetch

Instruction-fetch stage that produces the fetch PC, instruction word, TLB-miss flag and delay-slot flag consumed by the IF/ID pipeline register. It owns the next-PC register and a single-outstanding request/acknowledge port to the instruction memory/MMU. It signals `ready` when a fetched word is presented, and honours pause, branch redirect and exception flush from downstream.

## Interface
- `RESET_PC`, 32'hBFC00000: first fetch address after reset.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `PauseSignal`  in  1  ID stall; the presented word is not consumed this cycle.
- `flush`  in  1  exception redirect.
- `flushTarget`  in  32  redirect PC, valid when `flush`=1.
- `branchFlag`  in  1  ID holds a taken branch/jump; qualifies the word consumed this cycle as its delay slot.
- `branchTarget`  in  32  branch destination, valid when `branchFlag`=1.
- `memReq`  out  1  fetch request; held until `memAck`.
- `memAddr`  out  32  fetch address; stable while `memReq`=1.
- `memAck`  in  1  one-cycle completion pulse; `memData`/`memTLBMiss` are valid only in this cycle.
- `memData`  in  32  fetched word.
- `memTLBMiss`  in  1  translation of `memAddr` missed.
- `ready`  out  1  `PC`/`Instruction`/`PCTLBMiss`/`IsInDelaySlot` are valid.
- `PC`  out  32  address of presented word.
- `Instruction`  out  32  presented word; forced 0 on TLB miss.
- `PCTLBMiss`  out  1  presented word's fetch missed the TLB.
- `IsInDelaySlot`  out  1  = `branchFlag & ready`.

## Operation
- State `state` ∈ {IDLE, REQ, HOLD, DROP}. Registers: `reqAddr` (outstanding address), `nextPC`, `holdData`, `holdMiss`.
- `accept` = `ready & ~PauseSignal & ~flush`. This is the handoff condition.
- `advance` = `branchFlag ? branchTarget : PC + 4`, modulo 2^32 (32'hFFFFFFFC+4 wraps to 0).
- IDLE: `memReq`=0. The next edge goes to REQ with `reqAddr`=`nextPC`.
- REQ: `memReq`=1, `memAddr`=`reqAddr`.
  - No ack: stay in REQ.
  - Ack: `ready`=1 combinationally, with `PC`=`reqAddr`, `Instruction`=`memTLBMiss`?0:`memData`, and `PCTLBMiss`=`memTLBMiss`.
  - Ack & accept: stay in REQ with `reqAddr`←`advance` (back-to-back fetch).
  - Ack & `flush`: stay in REQ with `reqAddr`←`flushTarget`; the word is discarded.
  - Ack & pause (no flush): go to HOLD and latch the word and miss flag.
- HOLD: `memReq`=0. `ready`=1 with latched values; `PC`=`reqAddr`.
  - Accept: go to REQ with `reqAddr`←`advance`.
  - `flush`: go to REQ with `reqAddr`←`flushTarget`.
  - Pause: stay in HOLD.
- DROP: the request cannot be aborted. `memReq`=1 and `memAddr`=`reqAddr` (old address); `ready`=0.
  - Ack: the data is discarded; go to REQ with `reqAddr`←`nextPC`.
- `flush` in REQ without ack: go to DROP with `nextPC`←`flushTarget`.
- `flush` in DROP: `nextPC`←`flushTarget` (the latest flush wins).
- Priority is `flush` > `accept` > pause.
- `branchFlag` only matters on accept; it is ignored otherwise.
- When `ready`=0: `PC`=`reqAddr`, `Instruction`=0, `PCTLBMiss`=0, `IsInDelaySlot`=0.

## Timing
- Reset (asynchronous, any time including mid-request) forces:
  - `state`=IDLE, `reqAddr`=`nextPC`=`RESET_PC`, hold registers 0.
  - Outputs: `memReq`=0, `memAddr`=`RESET_PC`, `ready`=0, `PC`=`RESET_PC`, `Instruction`=0, `PCTLBMiss`=0, `IsInDelaySlot`=0.
  - An ack arriving in the first cycle after reset is ignored.
- First request: `memReq` rises 1 cycle after reset deasserts.
- Fetch latency: `ready` is asserted in the same cycle as `memAck` (zero added latency).
- Sustained throughput: with ack every cycle and no pause, one word per cycle.
- After HOLD accept: `memReq` with the new address 1 cycle later.
- Flush in REQ without ack: DROP lasts until ack. The new request is issued the cycle after that ack.
- `memAddr` never changes while `memReq`=1 and ack is not yet seen.

## Test plan
- Reset release, ack on the 2nd `memReq` cycle with `memData`=32'h24020005 → `ready`=1 that cycle with `PC`=BFC00000 and `Instruction`=24020005. The next `memAddr` is BFC00004.
- Ack while `PauseSignal`=1 for 3 cycles → HOLD: `ready` stays 1, outputs are stable and `memReq`=0. On pause release the next request is to PC+4.
- Accept with `branchFlag`=1, `branchTarget`=80001000 → `IsInDelaySlot`=1 on the handoff cycle; the next `memAddr` is 80001000.
- Flush (`flushTarget`=80000180) in REQ two cycles before ack → `memAddr` holds the old address and `ready` stays 0 at ack. The following request is to 80000180.
- Ack with `memTLBMiss`=1, `memData`=FFFFFFFF → `Instruction`=0 and `PCTLBMiss`=1.
- Accept at `reqAddr`=FFFFFFFC → next `memAddr`=00000000. Reset asserted mid-REQ → all outputs return to reset values immediately.

Source files
------------

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction-fetch stage with single-outstanding memory port
//
// Owns the fetch address register and a request/acknowledge port to the
// instruction memory/MMU. A fetched word is presented to the IF/ID register
// in the same cycle as memAck. If ID is paused, the word is parked in hold
// registers. Branch redirects are taken on the handoff cycle. An exception
// flush either redirects immediately, or waits out an in-flight request
// that cannot be aborted.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-low reset
//   PauseSignal             ID stall, presented word not consumed
//   flush, flushTarget      exception redirect and its target PC
//   branchFlag, branchTarget taken branch in ID, delay slot qualifier
//   memReq, memAddr         fetch request (held until memAck) and address
//   memAck, memData,
//   memTLBMiss              one-cycle completion with word and miss flag
//   ready                   PC/Instruction/PCTLBMiss/IsInDelaySlot valid
//   PC, Instruction,
//   PCTLBMiss, IsInDelaySlot presented fetch results

module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        PauseSignal,
    input  logic        flush,
    input  logic [31:0] flushTarget,
    input  logic        branchFlag,
    input  logic [31:0] branchTarget,
    output logic        memReq,
    output logic [31:0] memAddr,
    input  logic        memAck,
    input  logic [31:0] memData,
    input  logic        memTLBMiss,
    output logic        ready,
    output logic [31:0] PC,
    output logic [31:0] Instruction,
    output logic        PCTLBMiss,
    output logic        IsInDelaySlot
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] next_pc_q, next_pc_d;
    logic [31:0] hold_data_q, hold_data_d;
    logic        hold_miss_q, hold_miss_d;

    logic        ready_c;
    logic        mem_req_c;
    logic [31:0] instr_c;
    logic        miss_c;
    logic [31:0] advance;
    logic [31:0] fetched_word;

    // The presented PC is always req_addr_q, so the sequential successor is
    // derived from it. The 32-bit add wraps naturally at the top of memory.
    assign advance      = branchFlag ? branchTarget : (req_addr_q + 32'd4);
    assign fetched_word = memTLBMiss ? 32'd0 : memData;

    always_comb begin
        state_d     = state_q;
        req_addr_d  = req_addr_q;
        next_pc_d   = next_pc_q;
        hold_data_d = hold_data_q;
        hold_miss_d = hold_miss_q;
        ready_c     = 1'b0;
        mem_req_c   = 1'b0;
        instr_c     = 32'd0;
        miss_c      = 1'b0;

        case (state_q)
            IDLE: begin
                // Any ack seen here is stale and is deliberately ignored.
                state_d    = REQ;
                req_addr_d = next_pc_q;
            end

            REQ: begin
                mem_req_c = 1'b1;
                if (memAck) begin
                    ready_c = 1'b1;
                    instr_c = fetched_word;
                    miss_c  = memTLBMiss;
                    if (flush) begin
                        req_addr_d = flushTarget;
                    end else if (!PauseSignal) begin
                        req_addr_d = advance;
                    end else begin
                        state_d     = HOLD;
                        hold_data_d = fetched_word;
                        hold_miss_d = memTLBMiss;
                    end
                end else if (flush) begin
                    // The in-flight request cannot be withdrawn. Remember
                    // where to go and let DROP absorb the stale ack.
                    state_d   = DROP;
                    next_pc_d = flushTarget;
                end
            end

            HOLD: begin
                ready_c = 1'b1;
                instr_c = hold_data_q;
                miss_c  = hold_miss_q;
                if (flush) begin
                    state_d    = REQ;
                    req_addr_d = flushTarget;
                end else if (!PauseSignal) begin
                    state_d    = REQ;
                    req_addr_d = advance;
                end
            end

            DROP: begin
                // Keep the old address on the bus until the ack arrives.
                mem_req_c = 1'b1;
                if (flush) begin
                    next_pc_d = flushTarget;
                end
                if (memAck) begin
                    state_d    = REQ;
                    // A flush in the same cycle as the ack overrides the target.
                    req_addr_d = flush ? flushTarget : next_pc_q;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            req_addr_q  <= RESET_PC;
            next_pc_q   <= RESET_PC;
            hold_data_q <= 32'd0;
            hold_miss_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            next_pc_q   <= next_pc_d;
            hold_data_q <= hold_data_d;
            hold_miss_q <= hold_miss_d;
        end
    end

    assign memReq        = mem_req_c;
    assign memAddr       = req_addr_q;
    assign ready         = ready_c;
    assign PC            = req_addr_q;
    assign Instruction   = instr_c;
    assign PCTLBMiss     = miss_c;
    assign IsInDelaySlot = branchFlag & ready_c;

endmodule
